// File: rtl/pic_ctrl_sync.sv
// pic_ctrl_sync: ICW/OCW sequencing, request latching and INTA acknowledge control for the PIC.
// Supplies masked requests to the priority resolver and drives the vector and cascade address.
module pic_ctrl_sync #(
   parameter int unsigned NUM_IR = 8,
   parameter int unsigned VEC_W  = $clog2(NUM_IR)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [3:0]        i_icw_flags,
   input  logic [2:0]        i_ocw_flags,
   input  logic [7:0]        i_data_in,
   input  logic              i_sp,
   input  logic [NUM_IR-1:0] i_ir,
   input  logic              i_inta_n,
   input  logic [VEC_W-1:0]  i_int_vec,
   input  logic [2:0]        i_cas_in,
   output logic [2:0]        o_cas_out,
   output logic              o_cas_oe,
   output logic [NUM_IR-1:0] o_irr_masked,
   output logic [NUM_IR-1:0] o_imr,
   output logic [1:0]        o_read_command,
   output logic              o_aeoi,
   output logic              o_ltim,
   output logic [7:0]        o_ocw2,
   output logic              o_ocw2_valid,
   output logic [7:0]        o_iv,
   output logic              o_iv_valid,
   output logic              o_first_ack,
   output logic              o_second_ack,
   output logic              o_init_done
);

   typedef enum logic [2:0] {InitIdle, InitWIcw2, InitWIcw3, InitWIcw4, InitReady} init_state_e;
   typedef enum logic [1:0] {AckIdle, Ack1, Ack2} ack_state_e;

   init_state_e       r_init_st;
   ack_state_e        r_ack_st;

   logic              r_ltim;
   logic              r_sngl;
   logic              r_ic4;
   logic [7:VEC_W]    r_icw2_hi;
   logic [7:0]        r_icw3;
   logic              r_aeoi;
   logic [NUM_IR-1:0] r_imr;
   logic [7:0]        r_ocw2;
   logic              r_ocw2_valid;
   logic [1:0]        r_rd_cmd;
   logic              r_init_done;

   logic [NUM_IR-1:0] r_ir_q;
   logic [NUM_IR-1:0] r_ir_rise;
   logic [NUM_IR-1:0] r_irr;

   logic              r_inta_q;
   logic [VEC_W-1:0]  r_vec_q;
   logic              r_cas_match;
   logic              r_first_ack;
   logic              r_second_ack;
   logic              r_iv_valid;
   logic              r_cas_oe;
   logic [2:0]        r_cas_out;
   logic [7:0]        r_iv;

   logic              w_icw1_wr;
   logic              w_fall;
   logic              w_rise;
   logic              w_ack2_entry;
   logic [NUM_IR-1:0] w_irr_clr;
   logic              w_slave_on_line;
   logic              w_owned;
   logic [2:0]        w_cas_vec;

   assign w_icw1_wr    = i_icw_flags[0];
   assign w_fall       = r_inta_q & ~i_inta_n;
   assign w_rise       = ~r_inta_q & i_inta_n;
   assign w_ack2_entry = (r_ack_st == Ack1) & w_fall & ~w_icw1_wr;
   assign w_irr_clr    = w_ack2_entry ? (NUM_IR'(1) << r_vec_q) : '0;
   assign w_cas_vec    = 3'(r_vec_q);

   // A master hands the vector to a slave when the acknowledged IR has a slave behind it.
   assign w_slave_on_line = i_sp & ~r_sngl & r_icw3[r_vec_q];
   assign w_owned = r_sngl | (i_sp & ~r_icw3[r_vec_q]) | (~i_sp & r_cas_match);

   // Initialisation sequencing and command registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_init_st    <= InitIdle;
         r_ltim       <= 1'b0;
         r_sngl       <= 1'b0;
         r_ic4        <= 1'b0;
         r_icw2_hi    <= '0;
         r_icw3       <= '0;
         r_aeoi       <= 1'b0;
         r_imr        <= '0;
         r_ocw2       <= '0;
         r_ocw2_valid <= 1'b0;
         r_rd_cmd     <= '0;
         r_init_done  <= 1'b0;
      end else begin
         r_ocw2_valid <= 1'b0;
         if (w_icw1_wr) begin
            r_ltim      <= i_data_in[3];
            r_sngl      <= i_data_in[1];
            r_ic4       <= i_data_in[0];
            r_imr       <= '0;
            r_icw3      <= '0;
            r_aeoi      <= 1'b0;
            r_init_done <= 1'b0;
            r_init_st   <= InitWIcw2;
         end else begin
            unique case (r_init_st)
               InitWIcw2: if (i_icw_flags[1]) begin
                  r_icw2_hi <= i_data_in[7:VEC_W];
                  if (!r_sngl) begin
                     r_init_st <= InitWIcw3;
                  end else if (r_ic4) begin
                     r_init_st <= InitWIcw4;
                  end else begin
                     r_init_st   <= InitReady;
                     r_init_done <= 1'b1;
                  end
               end
               InitWIcw3: if (i_icw_flags[2]) begin
                  r_icw3 <= i_data_in;
                  if (r_ic4) begin
                     r_init_st <= InitWIcw4;
                  end else begin
                     r_init_st   <= InitReady;
                     r_init_done <= 1'b1;
                  end
               end
               InitWIcw4: if (i_icw_flags[3]) begin
                  r_aeoi      <= i_data_in[1];
                  r_init_st   <= InitReady;
                  r_init_done <= 1'b1;
               end
               InitReady: begin
                  if (i_ocw_flags[0]) begin
                     r_imr <= i_data_in[NUM_IR-1:0];
                  end else if (i_ocw_flags[1]) begin
                     r_ocw2       <= i_data_in;
                     r_ocw2_valid <= 1'b1;
                  end else if (i_ocw_flags[2]) begin
                     r_rd_cmd <= i_data_in[1:0];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Request latching; in edge mode a new edge outranks the acknowledge clear
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ir_q    <= '0;
         r_ir_rise <= '0;
         r_irr     <= '0;
      end else begin
         r_ir_q    <= i_ir;
         r_ir_rise <= i_ir & ~r_ir_q;
         if (w_icw1_wr) begin
            r_irr <= '0;
         end else if (r_ltim) begin
            r_irr <= i_ir;
         end else begin
            r_irr <= (r_irr & ~w_irr_clr) | r_ir_rise;
         end
      end
   end

   // INTA handshake; outputs are registered decodes of the current state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inta_q     <= 1'b1;
         r_ack_st     <= AckIdle;
         r_vec_q      <= '0;
         r_cas_match  <= 1'b0;
         r_first_ack  <= 1'b0;
         r_second_ack <= 1'b0;
         r_iv_valid   <= 1'b0;
         r_cas_oe     <= 1'b0;
         r_cas_out    <= '0;
         r_iv         <= '0;
      end else begin
         r_inta_q     <= i_inta_n;
         r_first_ack  <= (r_ack_st == Ack1);
         r_second_ack <= (r_ack_st == Ack2);
         r_iv_valid   <= (r_ack_st == Ack2) & w_owned;
         r_cas_oe     <= (r_ack_st != AckIdle) & w_slave_on_line;
         r_cas_out    <= ((r_ack_st != AckIdle) & w_slave_on_line) ? w_cas_vec : 3'd0;
         r_iv         <= {r_icw2_hi, r_vec_q};
         if (w_icw1_wr) begin
            r_ack_st <= AckIdle;
         end else begin
            unique case (r_ack_st)
               AckIdle: if (w_fall && r_init_st == InitReady) begin
                  r_ack_st <= Ack1;
                  r_vec_q  <= i_int_vec;
               end
               Ack1: if (w_fall) begin
                  r_ack_st    <= Ack2;
                  r_cas_match <= (i_cas_in == r_icw3[2:0]);
               end
               Ack2: if (w_rise) r_ack_st <= AckIdle;
               default: r_ack_st <= AckIdle;
            endcase
         end
      end
   end

   assign o_cas_out      = r_cas_out;
   assign o_cas_oe       = r_cas_oe;
   assign o_irr_masked   = r_irr & ~r_imr;
   assign o_imr          = r_imr;
   assign o_read_command = r_rd_cmd;
   assign o_aeoi         = r_aeoi;
   assign o_ltim         = r_ltim;
   assign o_ocw2         = r_ocw2;
   assign o_ocw2_valid   = r_ocw2_valid;
   assign o_iv           = r_iv;
   assign o_iv_valid     = r_iv_valid;
   assign o_first_ack    = r_first_ack;
   assign o_second_ack   = r_second_ack;
   assign o_init_done    = r_init_done;

endmodule

// File: tb/tb_pic_ctrl_sync.sv
// Bench for pic_ctrl_sync: directed scenarios plus random traffic, checked every cycle against
// a behavioural model of the command, request and acknowledge rules.
module tb_pic_ctrl_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] icw_flags;
   logic [2:0] ocw_flags;
   logic [7:0] data_in;
   logic       sp;
   logic [7:0] ir;
   logic       inta_n;
   logic [2:0] int_vec;
   logic [2:0] cas_in;

   logic [2:0] cas_out;
   logic       cas_oe;
   logic [7:0] irr_masked;
   logic [7:0] imr;
   logic [1:0] read_command;
   logic       aeoi, ltim;
   logic [7:0] ocw2;
   logic       ocw2_valid;
   logic [7:0] iv;
   logic       iv_valid, first_ack, second_ack, init_done;

   logic [2:0] d4_cas_out;
   logic       d4_cas_oe;
   logic [3:0] d4_irr_masked;
   logic [3:0] d4_imr;
   logic [1:0] d4_read_command;
   logic       d4_aeoi, d4_ltim;
   logic [7:0] d4_ocw2;
   logic       d4_ocw2_valid;
   logic [7:0] d4_iv;
   logic       d4_iv_valid, d4_first_ack, d4_second_ack, d4_init_done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pic_ctrl_sync #(.NUM_IR(8)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_icw_flags(icw_flags), .i_ocw_flags(ocw_flags),
      .i_data_in(data_in), .i_sp(sp), .i_ir(ir), .i_inta_n(inta_n), .i_int_vec(int_vec),
      .i_cas_in(cas_in), .o_cas_out(cas_out), .o_cas_oe(cas_oe), .o_irr_masked(irr_masked),
      .o_imr(imr), .o_read_command(read_command), .o_aeoi(aeoi), .o_ltim(ltim), .o_ocw2(ocw2),
      .o_ocw2_valid(ocw2_valid), .o_iv(iv), .o_iv_valid(iv_valid), .o_first_ack(first_ack),
      .o_second_ack(second_ack), .o_init_done(init_done)
   );

   pic_ctrl_sync #(.NUM_IR(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_icw_flags(icw_flags), .i_ocw_flags(ocw_flags),
      .i_data_in(data_in), .i_sp(sp), .i_ir(ir[3:0]), .i_inta_n(inta_n),
      .i_int_vec(int_vec[1:0]), .i_cas_in(cas_in), .o_cas_out(d4_cas_out), .o_cas_oe(d4_cas_oe),
      .o_irr_masked(d4_irr_masked), .o_imr(d4_imr), .o_read_command(d4_read_command),
      .o_aeoi(d4_aeoi), .o_ltim(d4_ltim), .o_ocw2(d4_ocw2), .o_ocw2_valid(d4_ocw2_valid),
      .o_iv(d4_iv), .o_iv_valid(d4_iv_valid), .o_first_ack(d4_first_ack),
      .o_second_ack(d4_second_ack), .o_init_done(d4_init_done)
   );

   // Model state: phase 0 idle, 1..3 waiting for ICW2..ICW4, 4 ready; ack 0 idle, 1, 2.
   logic [7:0] m_icw1, m_icw2, m_icw3, m_icw4, m_imr, m_ocw2, m_ocw3;
   logic       m_ocw2v, m_done, m_inta_prev, m_match;
   int         m_phase, m_ack;
   logic [7:0] m_irr, m_irq, m_rise_d;
   logic [2:0] m_vec;
   logic       m_first, m_second, m_ivv, m_casoe;
   logic [2:0] m_casout;
   logic [7:0] m_iv, m_iv4;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                      input logic [31:0] exp);
      chk(name, dut_v, exp);
      chk({"model_", name}, mdl_v, exp);
   endtask

   task automatic model_step();
      logic fall, rise, sngl, sline, owns, ack2_in;
      logic [7:0] clr;
      if (rst) begin
         m_icw1 = 0; m_icw2 = 0; m_icw3 = 0; m_icw4 = 0; m_imr = 0; m_ocw2 = 0; m_ocw3 = 0;
         m_ocw2v = 0; m_phase = 0; m_done = 0; m_irr = 0; m_irq = 0; m_rise_d = 0;
         m_inta_prev = 1; m_ack = 0; m_vec = 0; m_match = 0;
         m_first = 0; m_second = 0; m_ivv = 0; m_casoe = 0; m_casout = 0; m_iv = 0; m_iv4 = 0;
         return;
      end
      fall  = m_inta_prev & ~inta_n;
      rise  = ~m_inta_prev & inta_n;
      sngl  = m_icw1[1];
      sline = sp & ~sngl & m_icw3[m_vec];
      owns  = sngl ? 1'b1 : (sp ? ~m_icw3[m_vec] : m_match);
      // Outputs reflect the acknowledge state held before this edge.
      m_first  = (m_ack == 1);
      m_second = (m_ack == 2);
      m_ivv    = (m_ack == 2) && owns;
      m_casoe  = (m_ack != 0) && sline;
      m_casout = m_casoe ? m_vec : 3'd0;
      m_iv     = {m_icw2[7:3], m_vec};
      m_iv4    = {m_icw2[7:2], m_vec[1:0]};
      ack2_in = (m_ack == 1) && fall && !icw_flags[0];
      clr = ack2_in ? (8'd1 << m_vec) : 8'd0;
      if (icw_flags[0]) m_irr = 0;
      else if (m_icw1[3]) m_irr = ir;
      else m_irr = (m_irr & ~clr) | m_rise_d;
      m_rise_d = ir & ~m_irq;
      m_irq = ir;
      m_inta_prev = inta_n;
      if (icw_flags[0]) m_ack = 0;
      else if (m_ack == 0 && fall && m_phase == 4) begin m_ack = 1; m_vec = int_vec; end
      else if (m_ack == 1 && fall) begin m_ack = 2; m_match = (cas_in == m_icw3[2:0]); end
      else if (m_ack == 2 && rise) m_ack = 0;
      m_ocw2v = 0;
      if (icw_flags[0]) begin
         m_icw1 = data_in; m_imr = 0; m_icw3 = 0; m_icw4 = 0; m_phase = 1;
      end else begin
         case (m_phase)
            1: if (icw_flags[1]) begin
                  m_icw2 = data_in;
                  m_phase = !m_icw1[1] ? 2 : (m_icw1[0] ? 3 : 4);
               end
            2: if (icw_flags[2]) begin m_icw3 = data_in; m_phase = m_icw1[0] ? 3 : 4; end
            3: if (icw_flags[3]) begin m_icw4 = data_in; m_phase = 4; end
            4: if (ocw_flags[0]) m_imr = data_in;
               else if (ocw_flags[1]) begin m_ocw2 = data_in; m_ocw2v = 1; end
               else if (ocw_flags[2]) m_ocw3 = data_in;
            default: ;
         endcase
      end
      m_done = (m_phase == 4);
   endtask

   task automatic check_all();
      chk("cas_out", 32'(cas_out), 32'(m_casout));
      chk("cas_oe", 32'(cas_oe), 32'(m_casoe));
      chk("irr_masked", 32'(irr_masked), 32'(m_irr & ~m_imr));
      chk("imr", 32'(imr), 32'(m_imr));
      chk("read_command", 32'(read_command), 32'(m_ocw3[1:0]));
      chk("aeoi", 32'(aeoi), 32'(m_icw4[1]));
      chk("ltim", 32'(ltim), 32'(m_icw1[3]));
      chk("ocw2", 32'(ocw2), 32'(m_ocw2));
      chk("ocw2_valid", 32'(ocw2_valid), 32'(m_ocw2v));
      chk("iv", 32'(iv), 32'(m_iv));
      chk("iv_valid", 32'(iv_valid), 32'(m_ivv));
      chk("first_ack", 32'(first_ack), 32'(m_first));
      chk("second_ack", 32'(second_ack), 32'(m_second));
      chk("init_done", 32'(init_done), 32'(m_done));
      chk("n4_iv", 32'(d4_iv), 32'(m_iv4));
      chk("n4_imr", 32'(d4_imr), 32'(m_imr[3:0]));
      chk("n4_init_done", 32'(d4_init_done), 32'(m_done));
      chk("n4_first_ack", 32'(d4_first_ack), 32'(m_first));
      chk("n4_second_ack", 32'(d4_second_ack), 32'(m_second));
      chk("n4_cfg", 32'({d4_aeoi, d4_ltim, d4_read_command, d4_ocw2_valid, d4_ocw2}),
          32'({m_icw4[1], m_icw1[3], m_ocw3[1:0], m_ocw2v, m_ocw2}));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic icw(input int k, input logic [7:0] d);
      icw_flags = 4'(1 << (k - 1));
      data_in = d;
      tick();
      icw_flags = 4'h0;
   endtask

   task automatic ocw(input logic [2:0] mask, input logic [7:0] d);
      ocw_flags = mask;
      data_in = d;
      tick();
      ocw_flags = 3'h0;
   endtask

   // pulse1 leaves the handshake in ACK1, pulse2 in ACK2 with inta_n still low.
   task automatic pulse1();
      inta_n = 1'b0; tick(); tick();
      inta_n = 1'b1; tick(); tick();
   endtask

   task automatic pulse2();
      inta_n = 1'b0; tick(); tick();
   endtask

   task automatic release_ack();
      inta_n = 1'b1; tick(); tick();
   endtask

   initial begin
      rst = 1'b1; icw_flags = 0; ocw_flags = 0; data_in = 0; sp = 0; ir = 0;
      inta_n = 1'b1; int_vec = 0; cas_in = 0;
      tick(); tick();
      pin("rst_iv", 32'(iv), 32'(m_iv), 32'h0);
      pin("rst_init_done", 32'(init_done), 32'(m_done), 32'h0);
      pin("rst_cas_oe", 32'(cas_oe), 32'(m_casoe), 32'h0);
      rst = 1'b0;
      tick();

      // Single mode, vector 0x45
      icw(1, 8'h1B); icw(2, 8'h40); icw(4, 8'h02);
      pin("sgl_init_done", 32'(init_done), 32'(m_done), 32'h1);
      pin("sgl_aeoi", 32'(aeoi), 32'(m_icw4[1]), 32'h1);
      int_vec = 3'd5;
      pulse1();
      pin("sgl_ack1_ivv", 32'(iv_valid), 32'(m_ivv), 32'h0);
      pulse2();
      pin("sgl_iv", 32'(iv), 32'(m_iv), 32'h45);
      pin("sgl_ivv", 32'(iv_valid), 32'(m_ivv), 32'h1);
      release_ack();
      pin("sgl_ivv_drop", 32'(iv_valid), 32'(m_ivv), 32'h0);

      // Cascade master with a slave on IR2
      sp = 1'b1;
      icw(1, 8'h11); icw(2, 8'h20); icw(3, 8'h04); icw(4, 8'h01);
      int_vec = 3'd2;
      pulse1();
      pin("mst_ack1_oe", 32'(cas_oe), 32'(m_casoe), 32'h1);
      pin("mst_ack1_cas", 32'(cas_out), 32'(m_casout), 32'h2);
      pulse2();
      pin("mst_ack2_oe", 32'(cas_oe), 32'(m_casoe), 32'h1);
      pin("mst_ack2_cas", 32'(cas_out), 32'(m_casout), 32'h2);
      pin("mst_ivv", 32'(iv_valid), 32'(m_ivv), 32'h0);
      release_ack();

      // Cascade slave, id 2
      sp = 1'b0;
      icw(1, 8'h11); icw(2, 8'h70); icw(3, 8'h02); icw(4, 8'h01);
      int_vec = 3'd3; cas_in = 3'd2;
      pulse1(); pulse2();
      pin("slv_iv", 32'(iv), 32'(m_iv), 32'h73);
      pin("slv_ivv_match", 32'(iv_valid), 32'(m_ivv), 32'h1);
      release_ack();
      cas_in = 3'd5;
      pulse1(); pulse2();
      pin("slv_ivv_miss", 32'(iv_valid), 32'(m_ivv), 32'h0);
      release_ack();

      // Edge mode with mask, then clear through the acknowledge
      ocw(3'b001, 8'hFE);
      ir = 8'h03; tick();
      ir = 8'h00; tick();
      pin("edge_irr", 32'(irr_masked), 32'(m_irr & ~m_imr), 32'h01);
      int_vec = 3'd0; cas_in = 3'd2;
      pulse1(); pulse2();
      pin("edge_clr", 32'(irr_masked), 32'(m_irr & ~m_imr), 32'h00);
      release_ack();

      // Level mode
      icw(1, 8'h1B);
      ir = 8'h02; tick(); tick();
      pin("lvl_irr", 32'(irr_masked), 32'(m_irr & ~m_imr), 32'h02);
      icw(2, 8'h40); icw(4, 8'h02); tick();
      pin("lvl_irr_held", 32'(irr_masked), 32'(m_irr & ~m_imr), 32'h02);
      ir = 8'h00;

      // ICW1 during ACK1
      ocw(3'b001, 8'h3C);
      int_vec = 3'd1;
      pulse1();
      pin("abort_first", 32'(first_ack), 32'(m_first), 32'h1);
      icw(1, 8'h13);
      pin("abort_imr", 32'(imr), 32'(m_imr), 32'h00);
      tick();
      pin("abort_idle", 32'(first_ack), 32'(m_first), 32'h0);
      icw(2, 8'h80); icw(4, 8'h00);

      // OCW priority
      ocw(3'b100, 8'h03);
      pin("ocw3_rc", 32'(read_command), 32'(m_ocw3[1:0]), 32'h3);
      ocw(3'b010, 8'hA5);
      pin("ocw2_val", 32'(ocw2), 32'(m_ocw2), 32'hA5);
      pin("ocw2_pulse", 32'(ocw2_valid), 32'(m_ocw2v), 32'h1);
      tick();
      pin("ocw2_pulse_end", 32'(ocw2_valid), 32'(m_ocw2v), 32'h0);
      ocw(3'b101, 8'h5A);
      pin("ocw13_imr", 32'(imr), 32'(m_imr), 32'h5A);
      pin("ocw13_rc", 32'(read_command), 32'(m_ocw3[1:0]), 32'h3);

      // Vector width follows NUM_IR
      int_vec = 3'd3;
      pulse1(); pulse2();
      pin("n4_iv83", 32'(d4_iv), 32'(m_iv4), 32'h83);
      pin("n8_iv83", 32'(iv), 32'(m_iv), 32'h83);
      release_ack();

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 79) == 0) icw_flags = 4'($urandom) | 4'h1;
         else if ($urandom_range(0, 3) == 0) icw_flags = 4'($urandom) & 4'hE;
         else icw_flags = 4'h0;
         ocw_flags = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'h0;
         data_in = 8'($urandom);
         if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
         if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
         if ($urandom_range(0, 199) == 0) sp = ~sp;
         if ($urandom_range(0, 9) == 0) cas_in = 3'($urandom);
         int_vec = 3'($urandom);
         tick();
      end
      rst = 1'b0; icw_flags = 0; ocw_flags = 0; inta_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
